weighted_rr_arbiter: RTL

Two-requester weighted round-robin arbiter that decides, every cycle, which pipeline may use the shared resource. Each requester may keep ownership for a burst of up to its weight while it keeps requesting, then must yield if the other side is waiting. Grants are combinational from the current requests and registered state, so the shared-resource wrapper sees them in the request cycle and can derive its global stall as "no grant". Saturating per-requester grant counters are provided for performance debug.

---
 rtl/weighted_rr_arbiter_if.sv | 26 ++
 rtl/weighted_rr_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between the pipelines and the weighted round-robin arbiter.
// master: requester side (drives req_1/req_2/stat_clr, observes grants and status)
// slave : arbiter side (observes requests, drives grants, owner, burst and grant counters)
interface weighted_rr_arbiter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             req_1;
  logic             req_2;
  logic             stat_clr;
  logic             grant_1;
  logic             grant_2;
  logic [1:0]       owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [15:0]      grant_cnt_1;
  logic [15:0]      grant_cnt_2;

  modport master (
    output req_1, req_2, stat_clr,
    input  grant_1, grant_2, owner, burst_cnt, grant_cnt_1, grant_cnt_2
  );

  modport slave (
    input  req_1, req_2, stat_clr,
    output grant_1, grant_2, owner, burst_cnt, grant_cnt_1, grant_cnt_2
  );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Two-requester weighted round-robin arbiter.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave side of weighted_rr_arbiter_if:
//           req_1/req_2 in, stat_clr in (sync clear of grant counters),
//           grant_1/grant_2 out (combinational, same cycle as request),
//           owner out (00 idle, 01 req 1, 10 req 2), burst_cnt out,
//           grant_cnt_1/grant_cnt_2 out (saturating grant-cycle counters).
// An owner keeps the resource for up to its weight consecutive cycles while the
// other side waits; with no competitor it keeps the grant indefinitely.
module weighted_rr_arbiter #(
  parameter int unsigned WEIGHT_1 = 4,
  parameter int unsigned WEIGHT_2 = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  weighted_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] W1      = CNT_W'(WEIGHT_1);
  localparam logic [CNT_W-1:0] W2      = CNT_W'(WEIGHT_2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [15:0]      CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_1 = 2'b01,
    OWN_2 = 2'b10
  } owner_t;

  owner_t           state;
  logic [CNT_W-1:0] burst;
  logic             last_2;   // 1 when requester 2 was the most recent grantee
  logic [15:0]      cnt_1;
  logic [15:0]      cnt_2;
  logic             g1;
  logic             g2;

  // Grant decision from current requests and registered ownership state
  always_comb begin
    g1 = 1'b0;
    g2 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.req_1 && bus.req_2) begin
            g1 = last_2;
            g2 = !last_2;
          end else begin
            g1 = bus.req_1;
            g2 = bus.req_2;
          end
        end
        OWN_1: begin
          if (bus.req_1 && ((burst < W1) || !bus.req_2)) g1 = 1'b1;
          else if (bus.req_2)                            g2 = 1'b1;
        end
        OWN_2: begin
          if (bus.req_2 && ((burst < W2) || !bus.req_1)) g2 = 1'b1;
          else if (bus.req_1)                            g1 = 1'b1;
        end
        default: begin
          g1 = 1'b0;
          g2 = 1'b0;
        end
      endcase
    end
  end

  // Ownership, burst length and last-grantee tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      burst  <= '0;
      last_2 <= 1'b1;
    end else if (g1) begin
      last_2 <= 1'b0;
      if (state == OWN_1) begin
        if (burst < W1) burst <= burst + ONE;
      end else begin
        state <= OWN_1;
        burst <= ONE;
      end
    end else if (g2) begin
      last_2 <= 1'b1;
      if (state == OWN_2) begin
        if (burst < W2) burst <= burst + ONE;
      end else begin
        state <= OWN_2;
        burst <= ONE;
      end
    end else begin
      state <= IDLE;
      burst <= '0;
    end
  end

  // Saturating grant counters; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_1 <= '0;
      cnt_2 <= '0;
    end else if (bus.stat_clr) begin
      cnt_1 <= '0;
      cnt_2 <= '0;
    end else begin
      if (g1 && (cnt_1 != CNT_MAX)) cnt_1 <= cnt_1 + 16'd1;
      if (g2 && (cnt_2 != CNT_MAX)) cnt_2 <= cnt_2 + 16'd1;
    end
  end

  assign bus.grant_1     = g1;
  assign bus.grant_2     = g2;
  assign bus.owner       = state;
  assign bus.burst_cnt   = burst;
  assign bus.grant_cnt_1 = cnt_1;
  assign bus.grant_cnt_2 = cnt_2;

endmodule
